// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the byte-enabled RV32 data memory.
//   - ls_size_e : funct3 load/store size and sign encodings
//   - state_e   : init-sweep / run FSM states
//   - LANES     : byte lanes per 32-bit word
//   - load_extend(): picks the addressed byte/halfword and sign/zero-extends it

package dmem_pkg;

    localparam int unsigned LANES = 4;

    typedef enum logic [2:0] {
        LS_B  = 3'b000,
        LS_H  = 3'b001,
        LS_W  = 3'b010,
        LS_BU = 3'b100,
        LS_HU = 3'b101
    } ls_size_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Lane select plus extension of a word that has already been read.
    // Called only with funct3 values that passed the request checks.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        unique case (lane)
            2'd0: b = word[7:0];
            2'd1: b = word[15:8];
            2'd2: b = word[23:16];
            2'd3: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            LS_B:    r = {{24{b[7]}}, b};
            LS_BU:   r = {24'h0, b};
            LS_H:    r = {{16{h[15]}}, h};
            LS_HU:   r = {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_bytearray.sv
// dmem_bytearray: DEPTH x 32-bit storage organised as 4 byte lanes.
//   clk   : clock
//   rst   : asynchronous active-low reset (clears the read data register only)
//   we    : write enable
//   be    : per-lane byte write enable
//   waddr : write word index
//   wdata : write data, already replicated onto the enabled lanes
//   re    : read enable; rdata holds its value while re is low
//   raddr : read word index
//   rdata : registered read data

module dmem_bytearray
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [LANES-1:0] be,
    input  logic [AW-1:0]    waddr,
    input  logic [31:0]      wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [31:0]      rdata
);

    logic [LANES-1:0][7:0] mem [DEPTH];

    // Storage is not reset; the init sweep in the parent clears it.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    mem[waddr][i] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read register only moves on a read so the last load result stays stable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/datamemory_be.sv
// datamemory_be: byte-addressable RV32 data memory with valid/ready requests.
//   clk       : clock
//   rst       : asynchronous active-low reset
//   req_valid : request present
//   req_ready : high once the post-reset init sweep has finished
//   MemRead   : load request
//   MemWrite  : store request
//   funct3    : access size / sign (B, H, W, BU, HU)
//   a         : byte address
//   wd        : right-aligned store data
//   rsp_valid : one-cycle pulse, response to the request accepted last cycle
//   rd        : extended load data; 0 for store acks and errors
//   err       : request rejected (misaligned, out of range, bad funct3, read+write)

module datamemory_be
    import dmem_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DEPTH    = 1024,
    parameter logic [DATA_W-1:0] INIT_VAL = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] a,
    input  logic [DATA_W-1:0] wd,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rd,
    output logic              err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_e           state_q;
    logic [IDX_W-1:0] cnt_q;

    logic             accept;
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             out_of_range;
    logic             misalign;
    logic             bad_f3;
    logic             req_err;
    logic [LANES-1:0] be;
    logic [31:0]      wdata_lanes;

    logic             mem_we;
    logic [LANES-1:0] mem_be;
    logic [IDX_W-1:0] mem_waddr;
    logic [31:0]      mem_wdata;
    logic             mem_re;
    logic [31:0]      mem_rdata;

    logic             rsp_valid_q;
    logic             err_q;
    logic             ld_q;
    logic [2:0]       f3_q;
    logic [1:0]       lane_q;

    assign req_ready = (state_q == ST_RUN);

    // Requests with neither MemRead nor MemWrite are dropped without a response.
    assign accept = req_valid && req_ready && (MemRead || MemWrite);

    assign idx          = a[IDX_W+1:2];
    assign lane         = a[1:0];
    assign out_of_range = (a[ADDR_W-1:IDX_W+2] != '0);

    // Size decode: alignment, lane enables and store-data replication so that
    // the enabled lanes always see the low bytes of wd.
    always_comb begin
        misalign    = 1'b0;
        bad_f3      = 1'b0;
        be          = '0;
        wdata_lanes = wd;
        case (funct3)
            LS_B, LS_BU: begin
                be          = 4'b0001 << lane;
                wdata_lanes = {4{wd[7:0]}};
            end
            LS_H, LS_HU: begin
                misalign    = lane[0];
                be          = lane[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wd[15:0]}};
            end
            LS_W: begin
                misalign = |lane;
                be       = 4'b1111;
            end
            default: bad_f3 = 1'b1;
        endcase
        // Unsigned variants only make sense for loads.
        if (MemWrite && funct3[2]) begin
            bad_f3 = 1'b1;
        end
        req_err = out_of_range || misalign || bad_f3 || (MemRead && MemWrite);
    end

    // The sweep owns the write port during INIT; requests own it during RUN.
    // The sweep also writes while reset is held, which only rewrites word 0.
    always_comb begin
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_be    = '1;
            mem_waddr = cnt_q;
            mem_wdata = INIT_VAL;
        end else begin
            mem_we    = accept && MemWrite && !req_err;
            mem_be    = be;
            mem_waddr = idx;
            mem_wdata = wdata_lanes;
        end
    end

    assign mem_re = accept && MemRead && !req_err;

    dmem_bytearray #(
        .DEPTH (DEPTH),
        .AW    (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .be    (mem_be),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (idx),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (cnt_q == IDX_W'(DEPTH - 1)) begin
                        state_q <= ST_RUN;
                    end
                    cnt_q <= cnt_q + IDX_W'(1);
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_INIT;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Response state. Everything except rsp_valid only moves on an accept, so
    // rd/err hold the last response between requests.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            ld_q        <= 1'b0;
            f3_q        <= '0;
            lane_q      <= '0;
        end else begin
            rsp_valid_q <= accept;
            if (accept) begin
                err_q  <= req_err;
                ld_q   <= MemRead && !req_err;
                f3_q   <= funct3;
                lane_q <= lane;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign err       = err_q;
    assign rd        = ld_q ? load_extend(mem_rdata, f3_q, lane_q) : '0;

endmodule

// File: tb/tb_datamemory_be.sv
// Self-checking bench for datamemory_be (DEPTH = 16). Each request pushes its
// expected {err, rd} onto a scoreboard queue; the response cycle pops and compares.

module tb_datamemory_be;
    import dmem_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] wd;
    logic        rsp_valid;
    logic [31:0] rd;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [32:0] sb [$];

    typedef struct packed {
        logic        mr;
        logic        mw;
        logic [2:0]  op;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic        e_err;
        logic [31:0] e_rd;
    } req_t;

    always #5 clk = ~clk;

    datamemory_be #(
        .DATA_W   (32),
        .ADDR_W   (32),
        .DEPTH    (DEPTH),
        .INIT_VAL (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .funct3    (funct3),
        .a         (a),
        .wd        (wd),
        .rsp_valid (rsp_valid),
        .rd        (rd),
        .err       (err)
    );

    function automatic req_t st(input logic [2:0] o, input logic [31:0] ad,
                                input logic [31:0] d, input logic e);
        return '{mr: 1'b0, mw: 1'b1, op: o, adr: ad, wdat: d, e_err: e, e_rd: 32'h0};
    endfunction

    function automatic req_t ld(input logic [2:0] o, input logic [31:0] ad,
                                input logic e, input logic [31:0] r);
        return '{mr: 1'b1, mw: 1'b0, op: o, adr: ad, wdat: 32'h0, e_err: e, e_rd: r};
    endfunction

    // Drives one request for a single edge; returns #1 after that edge, where
    // the response to it (if any) is visible.
    task automatic send(input req_t r);
        req_valid = 1'b1;
        MemRead   = r.mr;
        MemWrite  = r.mw;
        funct3    = r.op;
        a         = r.adr;
        wd        = r.wdat;
        @(posedge clk);
        if (r.mr || r.mw) sb.push_back({r.e_err, r.e_rd});
        #1;
        req_valid = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
    endtask

    task automatic test_reset;
        int n;
        req_t t [2];
        logic [32:0] exp;
        rst = 1'b0;
        req_valid = 1'b0;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        funct3 = 3'b0;
        a = '0;
        wd = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, rsp_valid, err, rd} !== 35'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b valid=%b err=%b rd=%h, expected all 0",
                     req_ready, rsp_valid, err, rd);
        end
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!req_ready && n < 100);
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL init_cycles: got %0d cycles until ready, expected %0d", n, DEPTH);
        end
        t = '{ld(LS_W, 32'h14, 1'b0, 32'h0), ld(LS_W, 32'h3C, 1'b0, 32'h0)};
        foreach (t[i]) begin
            send(t[i]);
            exp = sb.pop_front();
            checks++;
            if (rsp_valid !== 1'b1 || {err, rd} !== exp) begin
                errors++;
                $display("FAIL init_load[%0d]: got valid=%b err=%b rd=%h, expected valid=1 err=%b rd=%h",
                         i, rsp_valid, err, rd, exp[32], exp[31:0]);
            end
        end
    endtask

    task automatic test_byte_stores;
        req_t t [8];
        logic [32:0] exp;
        t = '{st(LS_W, 32'h10, 32'h1122_3344, 1'b0),
              st(LS_B, 32'h12, 32'h0000_00AB, 1'b0),
              ld(LS_W, 32'h10, 1'b0, 32'h11AB_3344),
              ld(LS_B, 32'h12, 1'b0, 32'hFFFF_FFAB),
              ld(LS_BU, 32'h12, 1'b0, 32'h0000_00AB),
              ld(LS_B, 32'h13, 1'b0, 32'h0000_0011),
              st(LS_B, 32'h11, 32'hFFFF_FF80, 1'b0),
              ld(LS_W, 32'h10, 1'b0, 32'h11AB_8044)};
        foreach (t[i]) begin
            send(t[i]);
            exp = sb.pop_front();
            checks++;
            if (rsp_valid !== 1'b1 || {err, rd} !== exp) begin
                errors++;
                $display("FAIL bytes[%0d]: got valid=%b err=%b rd=%h, expected valid=1 err=%b rd=%h",
                         i, rsp_valid, err, rd, exp[32], exp[31:0]);
            end
        end
    endtask

    task automatic test_halfword;
        req_t t [8];
        logic [32:0] exp;
        t = '{st(LS_H, 32'h22, 32'hCAFE_8001, 1'b0),
              ld(LS_H, 32'h22, 1'b0, 32'hFFFF_8001),
              ld(LS_HU, 32'h22, 1'b0, 32'h0000_8001),
              ld(LS_W, 32'h20, 1'b0, 32'h8001_0000),
              ld(LS_H, 32'h23, 1'b1, 32'h0),
              st(LS_H, 32'h20, 32'h0000_7FFF, 1'b0),
              ld(LS_H, 32'h20, 1'b0, 32'h0000_7FFF),
              ld(LS_W, 32'h20, 1'b0, 32'h8001_7FFF)};
        foreach (t[i]) begin
            send(t[i]);
            exp = sb.pop_front();
            checks++;
            if (rsp_valid !== 1'b1 || {err, rd} !== exp) begin
                errors++;
                $display("FAIL half[%0d]: got valid=%b err=%b rd=%h, expected valid=1 err=%b rd=%h",
                         i, rsp_valid, err, rd, exp[32], exp[31:0]);
            end
        end
    endtask

    task automatic test_errors;
        req_t t [16];
        req_t both;
        req_t idle;
        logic [32:0] exp;
        both = '{mr: 1'b1, mw: 1'b1, op: LS_W, adr: 32'h04, wdat: 32'h0, e_err: 1'b1, e_rd: 32'h0};
        t = '{st(LS_W, 32'h04, 32'h0BAD_F00D, 1'b0),
              st(LS_W, 32'h06, 32'hFFFF_FFFF, 1'b1),
              ld(LS_W, 32'h04, 1'b0, 32'h0BAD_F00D),
              ld(LS_W, 32'h40, 1'b1, 32'h0),
              ld(LS_W, 32'h8000_0010, 1'b1, 32'h0),
              both,
              ld(LS_W, 32'h04, 1'b0, 32'h0BAD_F00D),
              st(LS_BU, 32'h04, 32'h0000_0000, 1'b1),
              ld(3'b011, 32'h04, 1'b1, 32'h0),
              ld(3'b110, 32'h04, 1'b1, 32'h0),
              ld(LS_HU, 32'h05, 1'b1, 32'h0),
              ld(LS_W, 32'h04, 1'b0, 32'h0BAD_F00D),
              ld(LS_B, 32'h05, 1'b0, 32'hFFFF_FFF0),
              ld(LS_BU, 32'h07, 1'b0, 32'h0000_000B),
              ld(LS_H, 32'h06, 1'b0, 32'h0000_0BAD),
              ld(LS_H, 32'h04, 1'b0, 32'hFFFF_F00D)};
        foreach (t[i]) begin
            send(t[i]);
            exp = sb.pop_front();
            checks++;
            if (rsp_valid !== 1'b1 || {err, rd} !== exp) begin
                errors++;
                $display("FAIL errors[%0d]: got valid=%b err=%b rd=%h, expected valid=1 err=%b rd=%h",
                         i, rsp_valid, err, rd, exp[32], exp[31:0]);
            end
        end
        // A valid request with neither read nor write gets no response; the
        // last response data stays on rd/err.
        idle = '{mr: 1'b0, mw: 1'b0, op: LS_W, adr: 32'h04, wdat: 32'h0, e_err: 1'b0, e_rd: 32'h0};
        send(idle);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL ignored_req: got rsp_valid=%b, expected 0", rsp_valid);
        end
        checks++;
        if ({err, rd} !== {1'b0, 32'hFFFF_F00D}) begin
            errors++;
            $display("FAIL held_rsp: got err=%b rd=%h, expected err=0 rd=fffff00d", err, rd);
        end
    endtask

    task automatic test_back_to_back;
        req_t t [7];
        logic [32:0] exp;
        // Last word of the 16-word array, so the pair stays in range.
        t = '{st(LS_W, 32'h3C, 32'hDEAD_BEEF, 1'b0),
              ld(LS_W, 32'h3C, 1'b0, 32'hDEAD_BEEF),
              st(LS_B, 32'h3D, 32'h0000_0055, 1'b0),
              ld(LS_W, 32'h3C, 1'b0, 32'hDEAD_55EF),
              st(LS_H, 32'h3E, 32'h0000_1234, 1'b0),
              ld(LS_HU, 32'h3E, 1'b0, 32'h0000_1234),
              ld(LS_W, 32'h3C, 1'b0, 32'h1234_55EF)};
        foreach (t[i]) begin
            send(t[i]);
            exp = sb.pop_front();
            checks++;
            if (rsp_valid !== 1'b1 || {err, rd} !== exp) begin
                errors++;
                $display("FAIL b2b[%0d]: got valid=%b err=%b rd=%h, expected valid=1 err=%b rd=%h",
                         i, rsp_valid, err, rd, exp[32], exp[31:0]);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rsp_pulse: got rsp_valid=%b one cycle after last response, expected 0",
                     rsp_valid);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        logic [32:0] exp;
        req_t t [1];
        send(ld(LS_W, 32'h10, 1'b0, 32'h11AB_8044));
        rst = 1'b0;
        sb.delete();
        #1;
        checks++;
        if ({req_ready, rsp_valid, err, rd} !== 35'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got ready=%b valid=%b err=%b rd=%h, expected all 0",
                     req_ready, rsp_valid, err, rd);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, rsp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_hold: got ready=%b valid=%b, expected 0 0",
                     req_ready, rsp_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!req_ready && n < 100);
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL reinit_cycles: got %0d cycles until ready, expected %0d", n, DEPTH);
        end
        // The restarted sweep must have cleared the previously written word.
        t = '{ld(LS_W, 32'h10, 1'b0, 32'h0)};
        foreach (t[i]) begin
            send(t[i]);
            exp = sb.pop_front();
            checks++;
            if (rsp_valid !== 1'b1 || {err, rd} !== exp) begin
                errors++;
                $display("FAIL reinit_load: got valid=%b err=%b rd=%h, expected valid=1 err=%b rd=%h",
                         rsp_valid, err, rd, exp[32], exp[31:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_byte_stores();
        test_halfword();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
